// File: rtl/bk_bus_pkg.sv
// bk_bus_pkg: register map, CSR bit positions, frame length and bus FSM states for bus-attached peripherals
package bk_bus_pkg;
  localparam logic [15:0] XCSR_OFS = 16'd0;
  localparam logic [15:0] XBUF_OFS = 16'd2;
  localparam int READY_BIT = 7;
  localparam int IE_BIT = 6;
  localparam int FRAME_BITS = 10;
  typedef enum logic {IDLE, ACK} bus_state_e;
endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: takes the holding byte when free and sends start, 8 data bits LSB first, stop
module uart_tx_shifter
  import bk_bus_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_baud,
  input  logic       hold_full,
  input  logic [7:0] hold_data,
  output logic       take,
  output logic       tx_out
);
  logic busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic last;
  assign last = cnt_q == 4'(FRAME_BITS - 1);
  // A pending byte is taken during the stop bit's closing tick, so frames run back to back
  assign take = ce_baud && hold_full && (!busy_q || last);
  assign tx_out = !busy_q || last || (cnt_q != 4'd0 && data_q[3'(cnt_q - 4'd1)]);
  always_comb begin
    busy_d = busy_q;
    cnt_d = cnt_q;
    data_d = data_q;
    if (take) begin
      busy_d = 1'b1;
      cnt_d = 4'd0;
      data_d = hold_data;
    end else if (ce_baud && busy_q) begin
      busy_d = !last;
      cnt_d = last ? 4'd0 : cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q <= 4'd0;
      data_q <= 8'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/xcvr_dl11_tx.sv
// xcvr_dl11_tx: DL11 console transmitter with bus responder, XCSR/XBUF registers and interrupt request
module xcvr_dl11_tx
  import bk_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'o177564,
  parameter logic [15:0] VEC = 16'o000064
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        ce_baud,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_din,
  input  logic        bus_sync,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  output logic [15:0] bus_dout,
  output logic        bus_ack,
  output logic        virq_req,
  input  logic        virq_ack,
  output logic        tx_out
);
  bus_state_e state_q, state_d;
  logic ready_q, ready_d, ie_q, ie_d, pend_q, pend_d;
  logic [7:0] hold_q, hold_d;
  logic sel, is_csr, is_buf, wr, load, take, pend_set, pend_clr;
  logic unused_ok;
  assign unused_ok = ^{VEC, BASE_ADDR[1:0], bus_din[15:8], bus_addr[0], bus_wtbt[1]};
  assign sel = bus_sync && bus_addr[15:2] == BASE_ADDR[15:2];
  assign is_csr = bus_addr[1] == XCSR_OFS[1];
  assign is_buf = bus_addr[1] == XBUF_OFS[1];
  // Only the IDLE->ACK step performs the access, so a held strobe cannot repeat it
  assign wr = ce && state_q == IDLE && sel && bus_stb && bus_we && bus_wtbt[0];
  assign load = wr && is_buf && ready_q;
  assign bus_ack = state_q == ACK;
  assign virq_req = pend_q;
  assign bus_dout = (sel && bus_stb && !bus_we && is_csr)
                  ? (16'(ready_q) << READY_BIT) | (16'(ie_q) << IE_BIT) : 16'd0;
  assign pend_set = ready_d && ie_d && !(ready_q && ie_q);
  assign pend_clr = virq_ack || load || (wr && is_csr && !bus_din[IE_BIT]);
  always_comb begin
    state_d = state_q;
    if (ce)
      state_d = (state_q == IDLE ? sel && bus_stb : bus_stb) ? ACK : IDLE;
    ie_d = wr && is_csr ? bus_din[IE_BIT] : ie_q;
    hold_d = load ? bus_din[7:0] : hold_q;
    ready_d = take ? 1'b1 : load ? 1'b0 : ready_q;
    pend_d = pend_clr ? 1'b0 : pend_set ? 1'b1 : pend_q;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      ie_q <= 1'b0;
      pend_q <= 1'b0;
      hold_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ie_q <= ie_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end
  uart_tx_shifter u_shifter (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_baud  (ce_baud),
    .hold_full(!ready_q),
    .hold_data(hold_q),
    .take     (take),
    .tx_out   (tx_out)
  );
endmodule

// File: tb/tb_xcvr_dl11_tx.sv
// tb_xcvr_dl11_tx: register vector table, directed frame/irq/reset sequences and a random byte stream
// checked by a line-level UART receiver feeding a byte scoreboard
module tb_xcvr_dl11_tx;
  localparam logic [15:0] CSR = 16'o177564;
  localparam logic [15:0] BUF = 16'o177566;
  logic clk_sys = 1'b0, reset = 1'b1, ce = 1'b1, ce_baud;
  logic bus_sync = 1'b0, bus_stb = 1'b0, bus_we = 1'b0, virq_ack = 1'b0;
  logic [15:0] bus_addr = '0, bus_din = '0;
  logic [1:0] bus_wtbt = '0;
  logic [15:0] bus_dout;
  logic bus_ack, virq_req, tx_out;
  logic [2:0] bcnt = '0;
  int n_cmp = 0, n_fail = 0;

  xcvr_dl11_tx dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .ce_baud(ce_baud),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_sync(bus_sync), .bus_stb(bus_stb),
    .bus_we(bus_we), .bus_wtbt(bus_wtbt), .bus_dout(bus_dout), .bus_ack(bus_ack),
    .virq_req(virq_req), .virq_ack(virq_ack), .tx_out(tx_out)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) bcnt <= bcnt + 3'd1;
  assign ce_baud = bcnt == 3'd7;

  // Line receiver: one sample per bit period, decodes frames into {stop, data}
  logic samples[$];
  logic [8:0] rx_mem[$];
  logic [7:0] rx_sh = '0;
  int rx_cnt = 0;
  always @(negedge clk_sys) begin
    if (reset) rx_cnt = 0;
    else if (ce_baud) begin
      samples.push_back(tx_out);
      if (rx_cnt == 0) begin
        if (!tx_out) rx_cnt = 1;
      end else if (rx_cnt <= 8) begin
        rx_sh[rx_cnt-1] = tx_out;
        rx_cnt++;
      end else begin
        rx_mem.push_back({tx_out, rx_sh});
        rx_cnt = 0;
      end
    end
  end

  logic [7:0] exp_q[$];
  int rd_idx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic [15:0] addr, input logic [1:0] wtbt,
                        input logic [15:0] din, output logic ack, output logic [15:0] dout,
                        output logic ack_after);
    bus_sync = 1'b1; bus_stb = 1'b1; bus_we = we; bus_addr = addr; bus_wtbt = wtbt; bus_din = din;
    @(negedge clk_sys);
    ack = bus_ack;
    dout = bus_dout;
    bus_sync = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
    @(negedge clk_sys);
    ack_after = bus_ack;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] din, output logic ack);
    logic [15:0] d;
    logic aa;
    bus_op(1'b1, addr, 2'b11, din, ack, d, aa);
  endtask

  task automatic rd(input logic [15:0] addr, output logic [15:0] dout);
    logic a, aa;
    bus_op(1'b0, addr, 2'b00, 16'd0, a, dout, aa);
  endtask

  task automatic wait_baud();
    do @(negedge clk_sys); while (!ce_baud);
  endtask

  task automatic wait_ready();
    logic [15:0] d;
    int i;
    for (i = 0; i < 30; i++) begin
      rd(CSR, d);
      if (d[7]) break;
    end
    if (i == 30) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_ready: READY still 0 after 30 polls, required 1");
    end
  endtask

  task automatic check_line(input string nm, input int idx, input logic [19:0] exp, input int n);
    int k = idx;
    logic [19:0] act = '0;
    while (k < samples.size() && samples[k]) k++;
    if (k + n > samples.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: start bit not seen, required frame %0h", nm, exp);
    end else begin
      for (int j = 0; j < n; j++) act[j] = samples[k+j];
      check(nm, 32'(act), 32'(exp));
    end
  endtask

  task automatic drain();
    logic [8:0] v;
    while (rd_idx < rx_mem.size()) begin
      v = rx_mem[rd_idx];
      rd_idx++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rx_extra: got byte %0h, required none", v[7:0]);
      end else begin
        check("rx_byte", 32'(v[7:0]), 32'(exp_q.pop_front()));
        check("rx_stop", 32'(v[8]), 32'd1);
      end
    end
  endtask

  typedef struct {
    logic we; logic [15:0] addr; logic [1:0] wtbt; logic [15:0] din;
    logic ack; logic [15:0] dout; logic irq;
  } vec_t;

  initial begin
    vec_t tbl[12];
    logic a, aa;
    logic [15:0] d;
    logic [7:0] b;
    logic [1:0] w;
    int idx, zeros;
    tbl[0]  = '{1'b0, CSR, 2'b00, 16'd0, 1'b1, 16'o000200, 1'b0};
    tbl[1]  = '{1'b0, BUF, 2'b00, 16'd0, 1'b1, 16'o000000, 1'b0};
    tbl[2]  = '{1'b0, CSR + 16'd4, 2'b00, 16'd0, 1'b0, 16'o000000, 1'b0};
    tbl[3]  = '{1'b1, CSR, 2'b11, 16'o000100, 1'b1, 16'o000000, 1'b1};
    tbl[4]  = '{1'b0, CSR, 2'b00, 16'd0, 1'b1, 16'o000300, 1'b1};
    tbl[5]  = '{1'b1, CSR, 2'b10, 16'o000000, 1'b1, 16'o000000, 1'b1};
    tbl[6]  = '{1'b0, CSR, 2'b00, 16'd0, 1'b1, 16'o000300, 1'b1};
    tbl[7]  = '{1'b1, CSR, 2'b01, 16'o000000, 1'b1, 16'o000000, 1'b0};
    tbl[8]  = '{1'b0, CSR, 2'b00, 16'd0, 1'b1, 16'o000200, 1'b0};
    tbl[9]  = '{1'b1, BUF, 2'b10, 16'h0033, 1'b1, 16'o000000, 1'b0};
    tbl[10] = '{1'b0, CSR, 2'b00, 16'd0, 1'b1, 16'o000200, 1'b0};
    tbl[11] = '{1'b0, CSR - 16'd2, 2'b00, 16'd0, 1'b0, 16'o000000, 1'b0};

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_ack", 32'(bus_ack), 32'd0);
    check("rst_irq", 32'(virq_req), 32'd0);

    foreach (tbl[i]) begin
      bus_op(tbl[i].we, tbl[i].addr, tbl[i].wtbt, tbl[i].din, a, d, aa);
      check($sformatf("vec%0d_ack", i), 32'(a), 32'(tbl[i].ack));
      check($sformatf("vec%0d_dout", i), 32'(d), 32'(tbl[i].dout));
      check($sformatf("vec%0d_ackdrop", i), 32'(aa), 32'd0);
      check($sformatf("vec%0d_irq", i), 32'(virq_req), 32'(tbl[i].irq));
    end

    // Single frame 0x41, READY low until the shifter takes it
    wait_baud();
    idx = samples.size();
    wr(BUF, 16'h0041, a);
    exp_q.push_back(8'h41);
    rd(CSR, d);
    check("x41_ready_low", 32'(d), 32'o000000);
    repeat (12) wait_baud();
    check_line("x41_line", idx, 20'({1'b1, 8'h41, 1'b0}), 10);
    rd(CSR, d);
    check("x41_ready_back", 32'(d), 32'o000200);
    drain();

    // Interrupt: set by IE, cleared by ack, by XBUF load, re-raised when READY returns
    wr(CSR, 16'o000100, a);
    check("irq_set", 32'(virq_req), 32'd1);
    virq_ack = 1'b1;
    @(negedge clk_sys);
    virq_ack = 1'b0;
    check("irq_ack", 32'(virq_req), 32'd0);
    @(negedge clk_sys);
    check("irq_stays", 32'(virq_req), 32'd0);
    wr(BUF, 16'h005A, a);
    exp_q.push_back(8'h5A);
    check("irq_load_clr", 32'(virq_req), 32'd0);
    repeat (2) wait_baud();
    @(negedge clk_sys);
    check("irq_ready_rise", 32'(virq_req), 32'd1);
    wr(CSR, 16'o000000, a);
    check("irq_ie_clr", 32'(virq_req), 32'd0);
    repeat (12) wait_baud();
    drain();

    // Back-to-back frames, third write ignored while READY=0
    idx = samples.size();
    wr(BUF, 16'h0055, a);
    exp_q.push_back(8'h55);
    wait_ready();
    wr(BUF, 16'h00AA, a);
    exp_q.push_back(8'hAA);
    check("b2b_ack2", 32'(a), 32'd1);
    wr(BUF, 16'h0077, a);
    check("b2b_ack3", 32'(a), 32'd1);
    rd(CSR, d);
    check("b2b_ready0", 32'(d), 32'o000000);
    repeat (24) wait_baud();
    check_line("b2b_line", idx, {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}, 20);
    drain();

    // Held strobe across a shifter take must not load a second time
    bus_sync = 1'b1; bus_stb = 1'b1; bus_we = 1'b1; bus_addr = BUF; bus_wtbt = 2'b11; bus_din = 16'h000F;
    exp_q.push_back(8'h0F);
    repeat (24) @(negedge clk_sys);
    check("held_ack", 32'(bus_ack), 32'd1);
    bus_sync = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
    @(negedge clk_sys);
    check("held_drop", 32'(bus_ack), 32'd0);
    repeat (24) wait_baud();
    drain();

    // Reset during data bit 3 (bit 4 of the frame) of 0xC3
    wait_baud();
    wr(BUF, 16'h00C3, a);
    repeat (5) wait_baud();
    @(negedge clk_sys);
    check("rst_mid_bit", 32'(tx_out), 32'd0);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_tx", 32'(tx_out), 32'd1);
    @(negedge clk_sys);
    reset = 1'b0;
    rd(CSR, d);
    check("rst_mid_ready", 32'(d), 32'o000200);
    idx = samples.size();
    repeat (12) wait_baud();
    zeros = 0;
    for (int j = idx; j < samples.size(); j++) zeros += samples[j] ? 0 : 1;
    check("rst_no_resume", 32'(zeros), 32'd0);
    idx = samples.size();
    wr(BUF, 16'h00C3, a);
    exp_q.push_back(8'hC3);
    repeat (12) wait_baud();
    check_line("rst_refrm", idx, 20'({1'b1, 8'hC3, 1'b0}), 10);
    drain();

    // Reset during a handshake drops ack
    bus_sync = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_addr = CSR;
    @(negedge clk_sys);
    check("hs_ack", 32'(bus_ack), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("hs_rst_ack", 32'(bus_ack), 32'd0);
    reset = 1'b0; bus_sync = 1'b0; bus_stb = 1'b0;
    @(negedge clk_sys);

    // Bus side only advances with ce
    ce = 1'b0; bus_sync = 1'b1; bus_stb = 1'b1; bus_addr = CSR;
    repeat (3) @(negedge clk_sys);
    check("ce_noack", 32'(bus_ack), 32'd0);
    ce = 1'b1;
    @(negedge clk_sys);
    check("ce_ack", 32'(bus_ack), 32'd1);
    ce = 1'b0; bus_sync = 1'b0; bus_stb = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("ce_hold", 32'(bus_ack), 32'd1);
    ce = 1'b1;
    @(negedge clk_sys);
    check("ce_release", 32'(bus_ack), 32'd0);

    // Random byte stream against the scoreboard
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk_sys);
      rd(CSR, d);
      if (d[7]) begin
        b = 8'($urandom);
        w = 2'($urandom_range(0, 3));
        bus_op(1'b1, BUF, w, {8'($urandom), b}, a, d, aa);
        check("rnd_ack", 32'(a), 32'd1);
        if (w[0]) exp_q.push_back(b);
      end
    end
    repeat (30) wait_baud();
    drain();
    check("rnd_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/xcvr_dl11_tx.md
XCVR_DL11_TX -- requirements
Module: xcvr_dl11_tx

Interface
REQ-001 Parameter BASE_ADDR, default 16'o177564; XCSR is at BASE_ADDR and XBUF at BASE_ADDR+2.
REQ-002 Parameter VEC, default 16'o000064; this is the vector number reported to the interrupt controller.
REQ-003 clk_sys  in  1  sole clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ce  in  1  bus clock enable (cpu phase); all bus-side state advances only when ce=1.
REQ-006 ce_baud  in  1  one pulse per serial bit time.
REQ-007 bus_addr  in  16  word address, valid while bus_sync=1.
REQ-008 bus_din  in  16  write data from the CPU.
REQ-009 bus_sync  in  1  address phase active.
REQ-010 bus_stb  in  1  data strobe, either read or write.
REQ-011 bus_we  in  1  1 = write cycle, 0 = read cycle.
REQ-012 bus_wtbt  in  2  byte enables; [0] = low byte, [1] = high byte.
REQ-013 bus_dout  out  16  read data; 16'd0 when not selected, so the CPU input mux can OR it with other sources.
REQ-014 bus_ack  out  1  reply to the CPU.
REQ-015 virq_req  out  1  interrupt request to the interrupt controller.
REQ-016 virq_ack  in  1  one-cycle acknowledge from the interrupt controller.
REQ-017 tx_out  out  1  serial line output; idle level is 1.

Function
REQ-018 sel SHALL be true when bus_sync=1 and bus_addr[15:2]==BASE_ADDR[15:2]; bus_addr[1] selects the register (0 = XCSR, 1 = XBUF).
REQ-019 Handshake FSM states and transitions:
- IDLE -> ACK on a ce cycle with sel & bus_stb.
- ACK holds bus_ack=1 until a ce cycle with bus_stb=0, then returns to IDLE.
- Exactly one register access is performed per ACK entry.
REQ-020 Read response: bus_dout = {8'd0, READY, IE, 6'd0} for XCSR and 16'd0 for XBUF; bus_dout is combinational, gated by sel & bus_stb & !bus_we.
REQ-021 XCSR write with bus_wtbt[0]=1 loads IE from bus_din[6]; the READY bit is read-only.
REQ-022 XBUF write with bus_wtbt[0]=1 while READY=1: HOLD <= bus_din[7:0] and READY <= 0. The same write while READY=0 is ignored; it is still acked.
REQ-023 A write with bus_wtbt[0]=0 is acked and has no effect.
REQ-024 Shifter takes HOLD on the first ce_baud after HOLD is full and the shifter is idle; READY <= 1 on that same cycle (double-buffered).
REQ-025 Frame is 10 bits, each held for one ce_baud period, in this order: start bit 0, data[0] through data[7], stop bit 1.
REQ-026 A 4-bit bit counter runs 0..9; the shifter returns to idle with tx_out=1 after the stop bit.
REQ-027 Back-to-back frames: a HOLD loaded mid-frame starts its start bit on the ce_baud immediately after the previous stop bit, with no idle gap.
REQ-028 The interrupt pending flag PEND is set on a rising edge of (READY & IE).
REQ-029 PEND is cleared by virq_ack, by a write of IE=0, or by an XBUF load.
REQ-030 virq_req = PEND.
REQ-031 If set and clear of PEND occur in the same cycle, clear wins.
REQ-032 An XBUF write and a shifter take of HOLD in the same cycle are resolved so that the shifter takes the old HOLD and the new write is ignored, because READY was 0 at the write.
REQ-033 A new transfer requires bus_stb to drop; a held bus_stb SHALL NOT cause a second access.

Reset
REQ-034 On reset=1 at posedge, the following take these values:
- READY=1, IE=0, PEND=0, HOLD=0.
- Shifter idle, bit counter=0, tx_out=1.
- Bus FSM in IDLE, bus_ack=0.
REQ-035 Reset mid-frame aborts the frame immediately: tx_out=1 on the next cycle and no partial resume.
REQ-036 Reset mid-handshake drops bus_ack in the next cycle.

Structure
REQ-037 The shared package bk_bus_pkg SHALL hold:
- the register offset constants XCSR_OFS and XBUF_OFS;
- the XCSR bit positions READY_BIT=7 and IE_BIT=6;
- the frame length constant FRAME_BITS=10;
- the bus FSM state enum (IDLE, ACK).
REQ-038 The block has one sub-module, uart_tx_shifter, containing HOLD-to-shift, the bit counter and tx_out. The bus responder, CSR and PEND logic live in the top module.

Verification
REQ-039 Read XCSR after reset, IE=0 -> bus_dout=16'o000200 and bus_ack=1 within 1 ce cycle of bus_stb; bus_ack=0 one ce cycle after bus_stb drops.
REQ-040 Write XBUF=16'h0041 -> tx_out sequence 0,1,0,0,0,0,0,1,0,1, each bit for one ce_baud period. READY is 0 from the write until the shifter takes HOLD.
REQ-041 Write XCSR=16'o000100 while READY=1 -> virq_req=1; pulse virq_ack -> virq_req=0 the next cycle.
REQ-042 Two XBUF writes 8'h55 then 8'hAA, the second issued mid-frame after READY returns to 1 -> 20 contiguous bits on tx_out with no idle gap. A third write while READY=0 is ignored and still acked.
REQ-043 Assert reset at bit 4 of a frame -> tx_out=1 and READY=1 on the next cycle. A subsequent XBUF write transmits a full frame.
REQ-044 Access to BASE_ADDR+4, or to XBUF with bus_wtbt=2'b10 -> respectively bus_ack=0 and bus_dout=0, or ack with no state change.
